// File: rtl/alu_seq.sv
// alu_seq: single-cycle integer ALU plus iterative unsigned multiply/divide
// with a valid/ready handshake in both directions and one operation in flight.
module alu_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    input  logic [3:0]      alu_control,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] alu_result,
    output logic            zero,
    output logic            greater,
    output logic            less,
    output logic            u_greater,
    output logic            u_less
);
    localparam int SHW = $clog2(XLEN);
    localparam int CW  = $clog2(XLEN + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t              r_state;
    logic                r_valid;
    logic [XLEN-1:0]     r_result;
    logic [XLEN-1:0]     r_opd;
    logic [2*XLEN-1:0]   r_acc;
    logic [CW-1:0]       r_cnt;
    logic [3:0]          r_op;
    logic                r_zero, r_greater, r_less, r_u_greater, r_u_less;

    logic                w_accept, w_iter, w_is_mul, w_hi;
    logic [SHW-1:0]      w_sh;
    logic [CW-1:0]       w_ctz, w_clz, w_cpop;
    logic [XLEN-1:0]     w_single, w_iter_res;
    logic [XLEN:0]       w_sum, w_rem_sh, w_trial;
    logic [2*XLEN-1:0]   w_mul_nxt, w_div_nxt;

    assign in_ready = !flush && ((r_state == IDLE) || ((r_state == DONE) && out_ready));
    assign w_accept = in_valid && in_ready;
    assign w_iter   = (alu_control == 4'b1000) || (alu_control == 4'b1001) ||
                      (alu_control == 4'b1101) || (alu_control == 4'b1110);
    assign w_sh     = B[SHW-1:0];

    always_comb begin
        w_ctz  = CW'(XLEN);
        w_clz  = CW'(XLEN);
        w_cpop = '0;
        for (int i = XLEN - 1; i >= 0; i--)
            if (A[i]) w_ctz = CW'(i);
        for (int i = 0; i < XLEN; i++) begin
            if (A[i]) w_clz = CW'(XLEN - 1 - i);
            w_cpop = w_cpop + CW'(A[i]);
        end
    end

    always_comb begin
        case (alu_control)
            4'b0000: w_single = A + B;
            4'b0001: w_single = A - B;
            4'b0010: w_single = A & B;
            4'b0011: w_single = A | B;
            4'b0100: w_single = A ^ B;
            4'b0101: w_single = A << w_sh;
            4'b0110: w_single = A >> w_sh;
            4'b0111: w_single = $unsigned($signed(A) >>> w_sh);
            4'b1010: w_single = XLEN'(w_ctz);
            4'b1011: w_single = XLEN'(w_clz);
            4'b1100: w_single = XLEN'(w_cpop);
            default: w_single = '0;
        endcase
    end

    // Multiply: low half of the accumulator starts as B and is consumed LSB first.
    assign w_sum     = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opd} : {(XLEN+1){1'b0}});
    assign w_mul_nxt = {w_sum, r_acc[XLEN-1:1]};
    // Divide: {remainder, dividend/quotient} shifts left, quotient bits enter at the bottom.
    assign w_rem_sh  = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
    assign w_trial   = w_rem_sh - {1'b0, r_opd};
    assign w_div_nxt = w_trial[XLEN] ? {w_rem_sh[XLEN-1:0], r_acc[XLEN-2:0], 1'b0}
                                     : {w_trial[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};

    assign w_is_mul   = !r_op[2];
    assign w_hi       = (r_op == 4'b1001) || (r_op == 4'b1110);
    assign w_iter_res = w_hi ? r_acc[2*XLEN-1:XLEN] : r_acc[XLEN-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_valid     <= 1'b0;
            r_result    <= '0;
            r_opd       <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_op        <= '0;
            r_zero      <= 1'b0;
            r_greater   <= 1'b0;
            r_less      <= 1'b0;
            r_u_greater <= 1'b0;
            r_u_less    <= 1'b0;
        end else if (flush) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_zero      <= A == B;
            r_greater   <= $signed(A) > $signed(B);
            r_less      <= $signed(A) < $signed(B);
            r_u_greater <= A > B;
            r_u_less    <= A < B;
            if (w_iter) begin
                r_state <= BUSY;
                r_valid <= 1'b0;
                r_cnt   <= CW'(XLEN);
                r_op    <= alu_control;
                r_opd   <= alu_control[2] ? B : A;
                r_acc   <= {{XLEN{1'b0}}, alu_control[2] ? A : B};
            end else begin
                r_state  <= DONE;
                r_valid  <= 1'b1;
                r_result <= w_single;
            end
        end else if (r_state == BUSY) begin
            if (r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
                r_acc <= w_is_mul ? w_mul_nxt : w_div_nxt;
            end else begin
                r_state  <= DONE;
                r_valid  <= 1'b1;
                r_result <= w_iter_res;
            end
        end else if ((r_state == DONE) && out_ready) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
        end
    end

    assign out_valid  = r_valid;
    assign alu_result = r_result;
    assign zero       = r_zero;
    assign greater    = r_greater;
    assign less       = r_less;
    assign u_greater  = r_u_greater;
    assign u_less     = r_u_less;
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vectors with hand-computed results for alu_seq.
module tb_alu_seq;
    logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
    logic [31:0] A = '0, B = '0;
    logic [3:0]  alu_control = '0;
    logic        in_ready, out_valid, zero, greater, less, u_greater, u_less;
    logic [31:0] alu_result;
    int          checks = 0, errors = 0;

    alu_seq #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .alu_control(alu_control), .out_valid(out_valid), .out_ready(out_ready),
        .alu_result(alu_result), .zero(zero), .greater(greater), .less(less),
        .u_greater(u_greater), .u_less(u_less)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        in_valid    = 1'b1;
        alu_control = op;
        A           = a;
        B           = b;
    endtask

    task automatic single(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        drive(op, a, b);
        step;
        check({tag, " res"}, alu_result, exp);
        check({tag, " vld"}, {31'b0, out_valid}, 32'd1);
    endtask

    task automatic run_iter(input string tag, input logic [3:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] exp);
        int   n;
        logic rdy_seen;
        drive(op, a, b);
        step;
        in_valid = 1'b0;
        A        = 32'h0;
        B        = 32'h0;
        n        = 0;
        rdy_seen = 1'b0;
        while (!out_valid && n < 100) begin
            if (in_ready) rdy_seen = 1'b1;
            step;
            n++;
        end
        check({tag, " lat"}, n, 32'd33);
        check({tag, " res"}, alu_result, exp);
        check({tag, " busy_rdy"}, {31'b0, rdy_seen}, 32'd0);
    endtask

    initial begin
        logic seen;
        #12 rst_n = 1'b1;
        step;
        check("rst vld", {31'b0, out_valid}, 32'd0);
        check("rst res", alu_result, 32'd0);
        check("rst rdy", {31'b0, in_ready}, 32'd1);

        single("add", 4'b0000, 32'd5, 32'd7, 32'd12);
        check("add less", {31'b0, less}, 32'd1);
        single("sub", 4'b0001, 32'd3, 32'd5, 32'hFFFFFFFE);
        check("sub less", {31'b0, less}, 32'd1);
        check("sub uless", {31'b0, u_less}, 32'd1);
        single("sra", 4'b0111, 32'h80000000, 32'd4, 32'hF8000000);
        check("sra less", {31'b0, less}, 32'd1);
        check("sra ugt", {31'b0, u_greater}, 32'd1);
        check("sra gt", {31'b0, greater}, 32'd0);
        single("clz", 4'b1011, 32'h00010000, 32'd0, 32'd15);
        single("and", 4'b0010, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000);
        single("or", 4'b0011, 32'hF0F0F0F0, 32'h0F0F0000, 32'hFFFFF0F0);
        single("xor", 4'b0100, 32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F);
        single("sll", 4'b0101, 32'd1, 32'h23, 32'd8);
        single("srl", 4'b0110, 32'h80000000, 32'd31, 32'd1);
        single("ctz0", 4'b1010, 32'd0, 32'd0, 32'd32);
        single("ctz", 4'b1010, 32'h00000100, 32'd0, 32'd8);
        single("clz0", 4'b1011, 32'd0, 32'd0, 32'd32);
        single("cpop", 4'b1100, 32'h0000F00F, 32'd0, 32'd8);
        single("rsvd", 4'b1111, 32'd5, 32'd5, 32'd0);
        check("rsvd zero", {31'b0, zero}, 32'd1);
        in_valid = 1'b0;
        step;
        check("idle vld", {31'b0, out_valid}, 32'd0);

        run_iter("mulhu", 4'b1001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
        run_iter("mul", 4'b1000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001);
        run_iter("mul2", 4'b1000, 32'd1234, 32'd5678, 32'd7006652);
        run_iter("divu", 4'b1101, 32'd100, 32'd7, 32'd14);
        run_iter("remu", 4'b1110, 32'd100, 32'd7, 32'd2);
        run_iter("divu0", 4'b1101, 32'h12345678, 32'd0, 32'hFFFFFFFF);
        run_iter("remu0", 4'b1110, 32'd9, 32'd0, 32'd9);
        step;

        out_ready = 1'b0;
        drive(4'b1100, 32'hFFFFFFFF, 32'd0);
        step;
        check("bp cpop", alu_result, 32'd32);
        drive(4'b0000, 32'd2, 32'd3);
        for (int i = 0; i < 5; i++) begin
            step;
            check("bp hold res", alu_result, 32'd32);
            check("bp hold vld", {31'b0, out_valid}, 32'd1);
            check("bp hold rdy", {31'b0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        #1 check("bp rel rdy", {31'b0, in_ready}, 32'd1);
        step;
        check("bp add res", alu_result, 32'd5);
        check("bp add vld", {31'b0, out_valid}, 32'd1);
        in_valid = 1'b0;
        step;
        check("bp drain vld", {31'b0, out_valid}, 32'd0);

        drive(4'b1101, 32'd100, 32'd7);
        step;
        in_valid = 1'b0;
        repeat (10) step;
        flush = 1'b1;
        #1 check("fl rdy low", {31'b0, in_ready}, 32'd0);
        step;
        flush = 1'b0;
        #1 check("fl rdy", {31'b0, in_ready}, 32'd1);
        check("fl vld", {31'b0, out_valid}, 32'd0);
        seen = 1'b0;
        repeat (40) begin
            step;
            if (out_valid) seen = 1'b1;
        end
        check("fl no result", {31'b0, seen}, 32'd0);
        single("fl add", 4'b0000, 32'd1, 32'd1, 32'd2);
        in_valid = 1'b0;

        step;
        drive(4'b1000, 32'd3, 32'd4);
        step;
        in_valid = 1'b0;
        repeat (5) step;
        #3 rst_n = 1'b0;
        #1 check("ar vld", {31'b0, out_valid}, 32'd0);
        check("ar res", alu_result, 32'd0);
        #2 rst_n = 1'b1;
        step;
        check("ar rdy", {31'b0, in_ready}, 32'd1);
        seen = 1'b0;
        repeat (40) begin
            step;
            if (out_valid) seen = 1'b1;
        end
        check("ar discard", {31'b0, seen}, 32'd0);
        single("ar add", 4'b0000, 32'd10, 32'd20, 32'd30);
        in_valid = 1'b0;
        step;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised-width execution unit for the superscalar integer pipe.
- Covers the existing single-cycle ALU operation set plus iterative unsigned multiply and divide.
- Uses a valid/ready handshake on both input and output. Holds at most one operation in flight.
- Result and comparison flags are registered. A later instance per issue lane is intended.

Parameters:
- XLEN, 32, operand/result width; must be a power of two, at least 8.
- SHW, $clog2(XLEN), shift-amount width; derived, do not override.
- CW, $clog2(XLEN+1), iteration counter width; derived.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous abort of any in-flight or held operation.
- in_valid  input  1  operation request.
- in_ready  output  1  unit can accept this cycle.
- A  input  XLEN  operand A.
- B  input  XLEN  operand B.
- alu_control  input  4  opcode.
- out_valid  output  1  result held.
- out_ready  input  1  consumer takes result.
- alu_result  output  XLEN  registered result.
- zero  output  1  A==B, captured operands.
- greater, less  output  1  signed A>B, A<B.
- u_greater, u_less  output  1  unsigned A>B, A<B.

Behaviour:
- Opcodes:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR.
  - 0101 SLL, 0110 SRL, 0111 SRA; shift amount is B[SHW-1:0].
  - 1000 MUL, low XLEN bits of A*B.
  - 1001 MULHU, high XLEN bits of unsigned A*B.
  - 1010 CTZ, 1011 CLZ, 1100 CPOP.
  - 1101 DIVU, 1110 REMU.
  - 1111 reserved; result 0, treated as single-cycle.
- Add/subtract mode is derived from the opcode: SUB only. There is no separate mode input.
- States: IDLE, BUSY, DONE.
- Reset (async, rst_n=0): state=IDLE, out_valid=0, alu_result=0, all flags=0, counter=0, partial registers=0.
- in_ready = (state==IDLE) | (state==DONE & out_ready). It is 0 in BUSY and whenever flush=1.
- Accept when in_valid & in_ready. On accept, flags are computed from A/B and registered, for every opcode.
- Single-cycle op accepted: alu_result is registered; state=DONE; out_valid=1 the next cycle (latency 1). Back-to-back accepts give throughput 1/cycle while out_ready=1.
- MUL/MULHU/DIVU/REMU accepted: state=BUSY, counter=XLEN. Operands go into internal registers.
- Multiply: shift-add, one bit of B per cycle, 2*XLEN-bit accumulator.
- Divide: restoring, one quotient bit per cycle.
- Counter decrements each BUSY cycle. When it reaches 0, the result is written and the state moves to DONE.
- out_valid rises exactly XLEN+1 cycles after the accept edge.
- DONE: outputs are held stable until out_ready=1.
  - out_ready=1 with no new accept: state goes to IDLE, out_valid=0.
  - out_ready=1 with a new accept: transfer and accept occur in the same cycle, handled as a fresh accept.
- Divide by zero (B==0): DIVU gives all ones, REMU gives A. Latency is still XLEN+1 (no early exit).
- CTZ/CLZ of zero gives XLEN. CPOP of all ones gives XLEN.
- All arithmetic is modulo 2^XLEN. No overflow flag.
- flush=1: next state IDLE, out_valid=0, counter cleared, no accept that cycle. flush has priority over out_ready and in_valid.
  - alu_result and the flags keep their last value. Consumers must qualify them with out_valid.
- in_valid while BUSY is ignored; the requester must hold the request.
- A, B and alu_control may change after accept without effect.
- rst_n assertion mid-BUSY discards the operation immediately.

Test Plan:
- Reset: rst_n=0 asynchronously mid-cycle -> out_valid=0, alu_result=0, in_ready=1 after release.
- Single-cycle stream: ADD 5+7, SUB 3-5, SRA 0x80000000>>4, CLZ 0x00010000, each with in_valid=1 and out_ready=1.
  - Results 12, 0xFFFFFFFE, 0xF8000000, 15 on consecutive cycles.
  - SUB 3-5 sets less=1 and u_less=1.
- Multiply: MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE after 33 cycles. MUL of the same operands -> 0x00000001. in_ready=0 throughout BUSY.
- Divide: DIVU 100/7 -> 14; REMU 100/7 -> 2; DIVU x/0 -> 0xFFFFFFFF; REMU 9/0 -> 9.
- Backpressure: hold out_ready=0 for 5 cycles after CPOP 0xFFFFFFFF -> alu_result stays 32 and out_valid stays 1. Release -> transfer, and the queued ADD is accepted the same cycle.
- Flush: assert flush 10 cycles into DIVU -> out_valid never rises, in_ready=1 the next cycle. A subsequent ADD 1+1 returns 2.
